// File: rtl/floating_point_to_int_pkg.sv
// Shared float32 types for the FPU blocks: unpacked operand struct,
// result-state encoding and format constants.
package float_struct;

    localparam int FP_BIAS    = 127;
    localparam int FP_EXP_MAX = 255;
    localparam int FP_MANT_W  = 24;

    typedef struct packed {
        logic                 sign;
        logic [7:0]           exp;
        logic [FP_MANT_W-1:0] mant;
    } float_point_num;

    typedef enum logic [1:0] {
        OK  = 2'b00,
        NAN = 2'b01,
        INF = 2'b10,
        NUL = 2'b11
    } states;

    // Mantissa carries the hidden one; callers classify exp=0 separately.
    function automatic float_point_num unpack_fp(input logic [31:0] x);
        float_point_num f;
        f.sign = x[31];
        f.exp  = x[30:23];
        f.mant = {1'b1, x[22:0]};
        return f;
    endfunction

endpackage

// File: rtl/floating_point_to_int_shift_reg_base.sv
// Generic shift register with tap outputs.
// Ports: clk, rst (sync, active-high), en, d[WIDTH], taps[STAGES][WIDTH].
module shift_reg_base #(
    parameter int STAGES = 3,
    parameter int WIDTH  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [WIDTH-1:0]              d,
    output logic [STAGES-1:0][WIDTH-1:0]  taps
);

    always_ff @(posedge clk) begin
        if (rst) begin
            taps <= '0;
        end else if (en) begin
            taps[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

endmodule

// File: rtl/floating_point_to_int.sv
// float32 -> int32 converter, round toward zero, 3-cycle latency.
// Ports: clk, rst (sync, active-high), a[32], arg_vld -> result[32],
// state[2] (OK/NAN/INF/NUL), res_vld.
module floating_point_to_int
    import float_struct::*;
#(
    parameter bit          SATURATE  = 1'b1,
    parameter logic [31:0] NAN_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic        arg_vld,
    output logic [31:0] result,
    output logic [1:0]  state,
    output logic        res_vld
);

    logic [2:0][0:0] vld;

    shift_reg_base #(
        .STAGES(3),
        .WIDTH (1)
    ) u_vld (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (arg_vld),
        .taps(vld)
    );

    // ---------------- stage 1: unpack / classify
    float_point_num   fp;
    logic             frac_nz;
    logic signed [8:0] sh_d;
    states            cls1_d;

    assign fp      = unpack_fp(a);
    assign frac_nz = |a[22:0];
    assign sh_d    = signed'({1'b0, fp.exp} - 9'(FP_BIAS));

    always_comb begin
        cls1_d = OK;
        unique case (1'b1)
            (fp.exp == 8'(FP_EXP_MAX)) && frac_nz:  cls1_d = NAN;
            (fp.exp == 8'(FP_EXP_MAX)) && !frac_nz: cls1_d = INF;
            (fp.exp == 8'd0):                       cls1_d = NUL;
            default:                                cls1_d = OK;
        endcase
    end

    logic                 s1_sign;
    logic                 s1_frac_nz;
    logic [FP_MANT_W-1:0] s1_mant;
    logic signed [8:0]    s1_sh;
    states                s1_cls;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sign    <= 1'b0;
            s1_frac_nz <= 1'b0;
            s1_mant    <= '0;
            s1_sh      <= '0;
            s1_cls     <= OK;
        end else if (arg_vld) begin
            s1_sign    <= fp.sign;
            s1_frac_nz <= frac_nz;
            s1_mant    <= fp.mant;
            s1_sh      <= sh_d;
            s1_cls     <= cls1_d;
        end
    end

    // ---------------- stage 2: range check / denormalise
    logic [31:0] wide;
    logic [4:0]  rsh;
    logic [4:0]  lsh;
    logic [31:0] mag_d;
    states       cls2_d;

    assign wide = {8'b0, s1_mant};
    assign rsh  = 5'd23 - s1_sh[4:0];
    assign lsh  = s1_sh[4:0] - 5'd23;

    always_comb begin
        mag_d  = '0;
        cls2_d = s1_cls;
        if (s1_cls == OK) begin
            unique case (1'b1)
                s1_sh < 9'sd0: cls2_d = NUL;
                s1_sh > 9'sd31: cls2_d = INF;
                s1_sh == 9'sd31: begin
                    // Only -2^31 itself is representable here.
                    if (s1_sign && !s1_frac_nz) begin
                        mag_d = 32'h8000_0000;
                    end else begin
                        cls2_d = INF;
                    end
                end
                (s1_sh >= 9'sd0) && (s1_sh <= 9'sd23):
                    mag_d = wide >> rsh;
                default: mag_d = wide << lsh;
            endcase
        end
    end

    logic        s2_sign;
    logic [31:0] s2_mag;
    states       s2_cls;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_sign <= 1'b0;
            s2_mag  <= '0;
            s2_cls  <= OK;
        end else if (vld[0][0]) begin
            s2_sign <= s1_sign;
            s2_mag  <= mag_d;
            s2_cls  <= cls2_d;
        end
    end

    // ---------------- stage 3: sign / pack
    logic [31:0] res_d;

    always_comb begin
        res_d = '0;
        unique case (s2_cls)
            OK:  res_d = s2_sign ? (32'd0 - s2_mag) : s2_mag;
            NUL: res_d = '0;
            NAN: res_d = NAN_VALUE;
            INF: begin
                if (SATURATE) begin
                    res_d = s2_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
                end else begin
                    res_d = '0;
                end
            end
            default: res_d = '0;
        endcase
    end

    states s3_cls;

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            s3_cls <= OK;
        end else if (vld[1][0]) begin
            result <= res_d;
            s3_cls <= s2_cls;
        end
    end

    assign state   = s3_cls;
    assign res_vld = vld[2][0];

endmodule
